// File: rtl/wb_bus_arbiter.sv
// Two-master / one-slave Wishbone classic arbiter.
// Master 0 is the Caravel management port and master 1 is the core data port.
// Round-robin arbitration picks the next owner, who keeps the bus for as long
// as its cyc stays high. A slave that stalls a strobe too long makes the
// arbiter return a one-cycle err to the owner.
module wb_bus_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                clk_i,
    input  logic                rst_i,
    // master 0 (Caravel host)
    input  logic                m0_cyc_i,
    input  logic                m0_stb_i,
    input  logic                m0_we_i,
    input  logic [DATA_W/8-1:0] m0_sel_i,
    input  logic [ADDR_W-1:0]   m0_adr_i,
    input  logic [DATA_W-1:0]   m0_dat_i,
    output logic                m0_ack_o,
    output logic                m0_err_o,
    output logic [DATA_W-1:0]   m0_dat_o,
    // master 1 (core)
    input  logic                m1_cyc_i,
    input  logic                m1_stb_i,
    input  logic                m1_we_i,
    input  logic [DATA_W/8-1:0] m1_sel_i,
    input  logic [ADDR_W-1:0]   m1_adr_i,
    input  logic [DATA_W-1:0]   m1_dat_i,
    output logic                m1_ack_o,
    output logic                m1_err_o,
    output logic [DATA_W-1:0]   m1_dat_o,
    // slave
    output logic                s_cyc_o,
    output logic                s_stb_o,
    output logic                s_we_o,
    output logic [DATA_W/8-1:0] s_sel_o,
    output logic [ADDR_W-1:0]   s_adr_o,
    output logic [DATA_W-1:0]   s_dat_o,
    input  logic                s_ack_i,
    input  logic [DATA_W-1:0]   s_dat_i,
    output logic [1:0]          grant_o
);

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

    state_t     state, state_nxt;
    logic       last, last_nxt;      // master granted most recently
    logic [7:0] cnt, cnt_nxt;        // cycles the current strobe has gone unacked
    logic       err_pend, err_nxt;   // timeout fires during this cycle
    logic       stall;

    // State, round-robin history and timeout tracking
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state    <= IDLE;
            last     <= 1'b1;        // m0 wins the first contention
            cnt      <= '0;
            err_pend <= 1'b0;
        end else begin
            state    <= state_nxt;
            last     <= last_nxt;
            cnt      <= cnt_nxt;
            err_pend <= err_nxt;
        end
    end

    // Next owner: grant from IDLE, hold while cyc stays high, hand over on release
    always_comb begin
        state_nxt = state;
        last_nxt  = last;
        case (state)
            IDLE: begin
                if (m0_cyc_i && m1_cyc_i) state_nxt = last ? GNT0 : GNT1;
                else if (m0_cyc_i)        state_nxt = GNT0;
                else if (m1_cyc_i)        state_nxt = GNT1;
            end
            GNT0: begin
                if (!m0_cyc_i) begin
                    last_nxt  = 1'b0;
                    state_nxt = m1_cyc_i ? GNT1 : IDLE;
                end
            end
            GNT1: begin
                if (!m1_cyc_i) begin
                    last_nxt  = 1'b1;
                    state_nxt = m0_cyc_i ? GNT0 : IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Route the owner's request to the slave and the slave's response back.
    // The strobe is suppressed during the error cycle, so a stalled slave
    // sees the access withdrawn. An ack in that cycle still beats the error.
    always_comb begin
        s_cyc_o  = 1'b0;
        s_stb_o  = 1'b0;
        s_we_o   = 1'b0;
        s_sel_o  = '0;
        s_adr_o  = '0;
        s_dat_o  = '0;
        m0_ack_o = 1'b0;
        m0_err_o = 1'b0;
        m0_dat_o = '0;
        m1_ack_o = 1'b0;
        m1_err_o = 1'b0;
        m1_dat_o = '0;
        grant_o  = 2'b00;
        case (state)
            GNT0: begin
                s_cyc_o  = m0_cyc_i;
                s_stb_o  = m0_stb_i & ~err_pend;
                s_we_o   = m0_we_i;
                s_sel_o  = m0_sel_i;
                s_adr_o  = m0_adr_i;
                s_dat_o  = m0_dat_i;
                m0_ack_o = s_ack_i;
                m0_err_o = err_pend & ~s_ack_i;
                m0_dat_o = s_dat_i;
                grant_o  = 2'b01;
            end
            GNT1: begin
                s_cyc_o  = m1_cyc_i;
                s_stb_o  = m1_stb_i & ~err_pend;
                s_we_o   = m1_we_i;
                s_sel_o  = m1_sel_i;
                s_adr_o  = m1_adr_i;
                s_dat_o  = m1_dat_i;
                m1_ack_o = s_ack_i;
                m1_err_o = err_pend & ~s_ack_i;
                m1_dat_o = s_dat_i;
                grant_o  = 2'b10;
            end
            default: ;
        endcase
    end

    assign stall = s_cyc_o & s_stb_o & ~s_ack_i;

    // Timeout counter: clears on ack, idle strobe or ownership change
    always_comb begin
        cnt_nxt = '0;
        err_nxt = 1'b0;
        if (stall && state_nxt == state) begin
            if (cnt == TO_LAST) err_nxt = 1'b1;
            else                cnt_nxt = cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_wb_bus_arbiter.sv
// Randomized bench for wb_bus_arbiter.
// A behavioural reference model tracks the owner, the round-robin history and
// how long the current strobe has stalled. It predicts every output of the
// arbiter on every cycle.
module tb_wb_bus_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int TO = 8;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          m0_cyc_i, m0_stb_i, m0_we_i, m1_cyc_i, m1_stb_i, m1_we_i;
    logic [SW-1:0] m0_sel_i, m1_sel_i;
    logic [AW-1:0] m0_adr_i, m1_adr_i;
    logic [DW-1:0] m0_dat_i, m1_dat_i;
    logic          m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
    logic [DW-1:0] m0_dat_o, m1_dat_o;
    logic          s_cyc_o, s_stb_o, s_we_o, s_ack_i;
    logic [SW-1:0] s_sel_o;
    logic [AW-1:0] s_adr_o;
    logic [DW-1:0] s_dat_o, s_dat_i;
    logic [1:0]    grant_o;

    always #5 clk_i = ~clk_i;

    wb_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i),
        .m0_sel_i(m0_sel_i), .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i),
        .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o), .m0_dat_o(m0_dat_o),
        .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i),
        .m1_sel_i(m1_sel_i), .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i),
        .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o), .m1_dat_o(m1_dat_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
        .s_sel_o(s_sel_o), .s_adr_o(s_adr_o), .s_dat_o(s_dat_o),
        .s_ack_i(s_ack_i), .s_dat_i(s_dat_i), .grant_o(grant_o)
    );

    int n_chk  = 0;
    int n_pass = 0;

    // reference model: owner (-1 idle), last granted, stalled-cycle age, err due now
    int own = -1;
    int last = 1;
    int age = 0;
    bit errp = 1'b0;
    int err_seen = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic drv(input bit c0, input bit s0, input bit c1, input bit s1, input bit ack);
        m0_cyc_i = c0;  m0_stb_i = s0;  m0_we_i = 1'($urandom);
        m0_sel_i = SW'($urandom); m0_adr_i = $urandom; m0_dat_i = $urandom;
        m1_cyc_i = c1;  m1_stb_i = s1;  m1_we_i = 1'($urandom);
        m1_sel_i = SW'($urandom); m1_adr_i = $urandom; m1_dat_i = $urandom;
        s_ack_i  = ack; s_dat_i = $urandom;
    endtask

    // check all outputs against the model, then advance one clock
    task automatic tick();
        bit mc[2];
        bit ms[2];
        bit stall;
        #3;
        if (rst_i) begin own = -1; last = 1; age = 0; errp = 1'b0; end
        mc[0] = m0_cyc_i; mc[1] = m1_cyc_i;
        ms[0] = m0_stb_i; ms[1] = m1_stb_i;
        chk("s_cyc", s_cyc_o, own >= 0 ? 64'(mc[own]) : 64'd0);
        chk("s_stb", s_stb_o, own >= 0 ? 64'(ms[own] && !errp) : 64'd0);
        chk("s_we",  s_we_o,  own == 0 ? 64'(m0_we_i)  : own == 1 ? 64'(m1_we_i)  : 64'd0);
        chk("s_sel", s_sel_o, own == 0 ? 64'(m0_sel_i) : own == 1 ? 64'(m1_sel_i) : 64'd0);
        chk("s_adr", s_adr_o, own == 0 ? 64'(m0_adr_i) : own == 1 ? 64'(m1_adr_i) : 64'd0);
        chk("s_dat", s_dat_o, own == 0 ? 64'(m0_dat_i) : own == 1 ? 64'(m1_dat_i) : 64'd0);
        chk("grant", grant_o, own == 0 ? 64'd1 : own == 1 ? 64'd2 : 64'd0);
        chk("m0_ack", m0_ack_o, 64'(own == 0 && s_ack_i));
        chk("m0_err", m0_err_o, 64'(own == 0 && errp && !s_ack_i));
        chk("m0_dat", m0_dat_o, own == 0 ? 64'(s_dat_i) : 64'd0);
        chk("m1_ack", m1_ack_o, 64'(own == 1 && s_ack_i));
        chk("m1_err", m1_err_o, 64'(own == 1 && errp && !s_ack_i));
        chk("m1_dat", m1_dat_o, own == 1 ? 64'(s_dat_i) : 64'd0);
        if (m0_err_o) err_seen++;
        @(posedge clk_i);
        if (rst_i) begin
            own = -1; last = 1; age = 0; errp = 1'b0;
        end else if (own < 0) begin
            if (mc[0] && mc[1]) own = 1 - last;
            else if (mc[0])     own = 0;
            else if (mc[1])     own = 1;
            age = 0; errp = 1'b0;
        end else if (!mc[own]) begin
            last = own;
            own  = mc[1 - own] ? 1 - own : -1;
            age = 0; errp = 1'b0;
        end else begin
            stall = ms[own] && !errp && !s_ack_i;
            errp = 1'b0;
            if (stall) begin
                age++;
                if (age == TO) begin errp = 1'b1; age = 0; end
            end else age = 0;
        end
        #1;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        drv(0, 0, 0, 0, 0);
        tick();
        tick();
        rst_i = 1'b0;
    endtask

    initial begin
        bit c0, c1;
        int ackp;
        do_reset();

        // m0 single read, slave acks on second granted cycle
        drv(1, 1, 0, 0, 0); tick();
        drv(1, 1, 0, 0, 0); #1 chk("rd_grant", grant_o, 2'b01); tick();
        drv(1, 1, 0, 0, 1); s_dat_i = 32'hDEAD_BEEF;
        #1 chk("rd_dat", m0_dat_o, 32'hDEAD_BEEF);
        chk("rd_ack", m0_ack_o, 1); chk("rd_m1_ack", m1_ack_o, 0);
        tick();
        drv(0, 0, 0, 0, 0); tick();

        // simultaneous request after reset: m0 first, then direct handover
        do_reset();
        drv(1, 1, 1, 1, 0); tick();
        drv(1, 1, 1, 1, 1); #1 chk("pair_first", grant_o, 2'b01); tick();
        drv(0, 0, 1, 1, 0); tick();
        drv(0, 0, 1, 1, 1); #1 chk("handover", grant_o, 2'b10); tick();
        drv(0, 0, 0, 0, 0); tick();
        // m0 served alone, then the next pair goes to m1
        drv(1, 1, 0, 0, 1); tick(); tick();
        drv(0, 0, 0, 0, 0); tick();
        drv(1, 1, 1, 1, 0); tick();
        drv(1, 1, 1, 1, 0); #1 chk("pair_rr", grant_o, 2'b10); tick();

        // m1 burst with stb gap while m0 waits
        foreach (ackp_pat[k]) begin
            drv(1, 1, 1, ackp_pat[k], ackp_pat[k]);
            #1 chk("burst_grant", grant_o, 2'b10); chk("burst_m0_ack", m0_ack_o, 0);
            tick();
        end
        drv(1, 1, 0, 0, 0); tick();
        drv(1, 1, 0, 0, 1); #1 chk("after_burst", grant_o, 2'b01); chk("after_burst_ack", m0_ack_o, 1); tick();
        drv(0, 0, 0, 0, 0); tick();

        // slave never acks: one err pulse on the 9th granted cycle, strobe withdrawn
        drv(1, 1, 0, 0, 0); tick();
        err_seen = 0;
        for (int i = 1; i <= 10; i++) begin
            drv(1, 1, 0, 0, 0);
            #1;
            if (i == TO + 1) begin
                chk("to_err", m0_err_o, 1); chk("to_stb", s_stb_o, 0);
            end
            tick();
        end
        chk("to_pulses", err_seen, 1);
        drv(0, 0, 0, 0, 0); tick();

        // ack on the threshold cycle beats the timeout
        drv(1, 1, 0, 0, 0); tick();
        err_seen = 0;
        for (int i = 1; i <= 10; i++) begin
            drv(1, 1, 0, 0, i == TO);
            #1;
            if (i == TO) chk("thr_ack", m0_ack_o, 1);
            tick();
        end
        chk("thr_no_err", err_seen, 0);
        drv(0, 0, 0, 0, 0); tick();

        // asynchronous reset in the middle of an m1 transfer
        drv(0, 0, 1, 1, 0); tick(); tick();
        drv(1, 1, 1, 1, 1);
        #1 chk("pre_rst_cyc", s_cyc_o, 1);
        #1 rst_i = 1'b1;
        #1 chk("arst_cyc", s_cyc_o, 0); chk("arst_grant", grant_o, 0); chk("arst_ack", m1_ack_o, 0);
        tick();
        rst_i = 1'b0;
        drv(1, 1, 1, 1, 0); tick();
        drv(1, 1, 1, 1, 0); #1 chk("post_rst_pair", grant_o, 2'b01); tick();
        drv(0, 0, 0, 0, 0); tick();

        // random traffic, alternating responsive and stalling slave phases
        c0 = 1'b0; c1 = 1'b0;
        for (int i = 0; i < 800; i++) begin
            ackp = ((i / 100) % 2) ? 0 : 50;
            if (ackp == 0) begin
                c0 = c0 ? ($urandom_range(0, 19) != 0) : ($urandom_range(0, 2) == 0);
                c1 = c1 ? ($urandom_range(0, 19) != 0) : ($urandom_range(0, 2) == 0);
                drv(c0, c0, c1, c1, $urandom_range(0, 99) < 3);
            end else begin
                c0 = c0 ? ($urandom_range(0, 5) != 0) : ($urandom_range(0, 2) == 0);
                c1 = c1 ? ($urandom_range(0, 5) != 0) : ($urandom_range(0, 2) == 0);
                drv(c0, c0 && ($urandom_range(0, 9) < 7), c1, c1 && ($urandom_range(0, 9) < 7),
                    $urandom_range(0, 99) < ackp);
            end
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    bit ackp_pat[5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};

endmodule

// File: doc/wb_bus_arbiter.md
Name: wb_bus_arbiter

Overview:
- Two-master, one-slave Wishbone classic arbiter inside `soc`.
- Shares the SoC internal peripheral/memory bus between the Caravel management Wishbone port (master 0) and the on-chip core's data port (master 1).
- Provides round-robin grant with bus lock for the duration of `cyc`.
- Includes a stalled-slave timeout that returns an error to the granted master.

Parameters:
- ADDR_W, 32, address width of all ports.
- DATA_W, 32, data width of all ports; SEL width = DATA_W/8.
- TIMEOUT, 255, cycles of unacknowledged strobe before err is raised (1..255, 8-bit counter).

Ports:
- clk_i  in  1  bus clock.
- rst_i  in  1  asynchronous active-high reset.
- m0_cyc_i, m0_stb_i, m0_we_i  in  1 each  master 0 (Caravel host) cycle/strobe/write.
- m0_sel_i  in  DATA_W/8  master 0 byte selects.
- m0_adr_i  in  ADDR_W  master 0 address.
- m0_dat_i  in  DATA_W  master 0 write data.
- m0_ack_o, m0_err_o  out  1 each  master 0 acknowledge/error.
- m0_dat_o  out  DATA_W  master 0 read data.
- m1_* (cyc, stb, we, sel, adr, dat_i, ack_o, err_o, dat_o)  same as m0_*  master 1 (core).
- s_cyc_o, s_stb_o, s_we_o  out  1 each  to slave.
- s_sel_o  out  DATA_W/8  to slave.
- s_adr_o  out  ADDR_W  to slave.
- s_dat_o  out  DATA_W  to slave.
- s_ack_i  in  1  slave acknowledge.
- s_dat_i  in  DATA_W  slave read data.
- grant_o  out  2  one-hot current owner (bit0 = m0, bit1 = m1); 00 when idle.

Behaviour:
- FSM states IDLE, GNT0, GNT1.
  - Registered `last` bit records the last master granted; reset value 1, so m0 wins the first contention.
- Reset (async, while rst_i=1):
  - state=IDLE, last=1, timeout counter=0.
  - All outputs 0: s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o, acks, errs, dat_o, grant_o.
  - Reset mid-transaction drops s_cyc_o immediately; no ack is delivered.
- IDLE transitions:
  - Only m0_cyc_i high -> GNT0.
  - Only m1_cyc_i high -> GNT1.
  - Both high -> grant the master not equal to `last` (round-robin).
  - None high -> stay IDLE.
- Grant latency: 1 cycle from cyc_i rising to s_cyc_o rising. Request sampled at edge N, grant_o and s_cyc_o valid after edge N.
- GNTx (owner x):
  - Slave outputs are a combinational mux of master x inputs: s_cyc_o = mx_cyc_i, s_stb_o = mx_stb_i, plus we, sel, adr, dat.
  - Routed to master x: mx_ack_o = s_ack_i, mx_dat_o = s_dat_i, mx_err_o = timeout pulse.
  - Non-owner: ack_o=0, err_o=0, dat_o=0.
- Bus lock: ownership is held while mx_cyc_i=1, including multiple stb beats and gaps with stb=0.
- Release: at the first edge where mx_cyc_i=0 in GNTx, set last=x.
  - Other master's cyc high -> go directly to its GNT state (no idle cycle).
  - Otherwise -> IDLE.
  - The released master re-requesting on that edge loses to a waiting other master.
- Non-owner during GNTx: its inputs are ignored, and it waits with cyc/stb held (Wishbone stall by absent ack).
- Timeout counter (8-bit):
  - Increments each cycle s_cyc_o & s_stb_o & !s_ack_i.
  - Clears on s_ack_i, on stb=0, or on a state change.
  - When count reaches TIMEOUT-1 without ack, the next cycle asserts mx_err_o=1 for exactly one cycle and forces s_stb_o=0 that cycle. The counter then clears.
  - The master is expected to drop cyc; ownership rules are unchanged.
- Simultaneous events:
  - s_ack_i in the same cycle as the timeout threshold: ack wins, no err.
  - Owner drops cyc while s_ack_i=1: ack is passed through that cycle, then the release proceeds.
- Widths: the mux is a pure select with no arithmetic. SEL width = DATA_W/8.

Test Plan:
- Reset, then m0 single read to adr 0x3000_0004, slave acks on 2nd cycle with 0xDEAD_BEEF -> grant_o=01 one cycle after cyc; m0_dat_o=0xDEAD_BEEF with m0_ack_o=1; m1_ack_o=0.
- m0 and m1 assert cyc on the same edge after reset -> m0 granted first. On m0 cyc drop, grant_o goes 01->10 on the very next edge with no idle cycle. Next simultaneous pair -> m1 granted first.
- m1 holds cyc for a 4-beat write burst (stb toggled 1,0,1,1,1) while m0 requests -> grant_o stays 10 for all beats; m0 sees no ack until m1 drops cyc.
- TIMEOUT=8, slave never acks m0 strobe -> m0_err_o pulses high for exactly 1 cycle, 8 cycles after stb; s_stb_o=0 in that cycle; counter=0 afterward.
- Slave acks on exactly the timeout-threshold cycle -> m0_ack_o=1, m0_err_o stays 0.
- rst_i asserted asynchronously mid-transfer of m1 (between clock edges) -> s_cyc_o, grant_o, m1_ack_o fall immediately. After release, a simultaneous request grants m0.
